// File: rtl/unified_memory.sv
// Single-port word memory for the multicycle core: one request at a time, fixed
// wait latency, then a one-cycle ready strobe with registered read data.
module unified_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misaligned,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: a request level seen in IDLE is accepted on that edge; the
    // response is the single cycle in RESP where ready=1 (rdata/misaligned valid).
    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_mis;
    logic            r_is_write;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_accept;
    logic            w_commit;
    logic            w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == S_IDLE) && w_req;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);

    // Address bits above the word index only wrap; they carry no meaning here.
    assign w_unused = ^{addr[31:AW+2]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_mis      <= 1'b0;
            r_is_write <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt      <= CW'(LATENCY - 1);
                r_idx      <= addr[AW+1:2];
                r_mis      <= (addr[1:0] != 2'b00);
                r_is_write <= mem_write;
                r_wdata    <= wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Writes leave rdata alone; a misaligned access of either kind clears it.
            if (w_commit) begin
                if (r_mis) begin
                    r_rdata <= '0;
                end else if (!r_is_write) begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    // Array has no reset; a reset on the commit edge still blocks the write.
    always_ff @(posedge clk) begin
        if (rst && w_commit && r_is_write && !r_mis) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rdata      = r_rdata;
    assign ready      = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign misaligned = (r_state == S_RESP) && r_mis;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_unified_memory.sv
// Scoreboard bench for unified_memory: three instances (LATENCY 1, 2, 4) driven
// with directed requests; a negedge monitor checks every ready strobe and busy.
module tb_unified_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  rst;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  ready;
    logic [2:0]  busy;
    logic [2:0]  misaligned;
    logic [1:0]  dbg_state [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_memory #(
            .DEPTH_WORDS(256),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .mem_read(mem_read[g]),
            .mem_write(mem_write[g]),
            .addr(addr[g]),
            .wdata(wdata[g]),
            .rdata(rdata[g]),
            .ready(ready[g]),
            .busy(busy[g]),
            .misaligned(misaligned[g]),
            .dbg_state(dbg_state[g])
        );
    end

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    typedef struct packed {
        logic [1:0]  dut;
        logic        mis;
        logic [31:0] rdata;
        logic [15:0] acc_cyc;
        logic [15:0] rdy_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] chk_busy = 3'b000;

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %h required %h", name, d, cyc, act, exp);
        end
    endtask

    // Monitor: busy must span accept..ready; every ready pops one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (chk_busy[d]) begin
                logic exp_b;
                exp_b = (exp_q.size() > 0) && (int'(exp_q[0].dut) == d) &&
                        (cyc >= int'(exp_q[0].acc_cyc));
                check("busy", d, 32'(busy[d]), 32'(exp_b));
            end
            if (ready[d]) begin
                if (exp_q.size() == 0 || int'(exp_q[0].dut) != d) begin
                    check("unexpected_ready", d, 32'(ready[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rdata", d, rdata[d], e.rdata);
                    check("misaligned", d, 32'(misaligned[d]), 32'(e.mis));
                    check("ready_cycle", d, 32'(cyc), 32'(e.rdy_cyc));
                end
            end else if (misaligned[d]) begin
                check("misaligned_without_ready", d, 32'(misaligned[d]), 32'd0);
            end
        end
    end

    task automatic push_exp(int d, int acc, logic [31:0] er, logic em);
        exp_t e;
        e.dut     = 2'(d);
        e.mis     = em;
        e.rdata   = er;
        e.acc_cyc = 16'(acc);
        e.rdy_cyc = 16'(acc + lat_of(d));
        exp_q.push_back(e);
    endtask

    task automatic scramble(int d);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        addr[d]      = 32'hFFFF_FFF3;
        wdata[d]     = 32'hBAD0_BAD0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout cyc %0d: %0d responses outstanding, required 0", cyc, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One-cycle request pulse; inputs are scrambled while the access is in flight.
    task automatic req(int d, logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                       logic [31:0] er, logic em);
        @(negedge clk);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr[d]      = a;
        wdata[d]     = wd;
        push_exp(d, cyc + 1, er, em);
        @(negedge clk);
        scramble(d);
        drain();
    endtask

    // Read held high through RESP: the second accept lands two cycles after ready.
    task automatic held_read(int d, logic [31:0] a, logic [31:0] er);
        int c;
        @(negedge clk);
        c = cyc;
        mem_read[d] = 1'b1;
        addr[d]     = a;
        push_exp(d, c + 1, er, 1'b0);
        push_exp(d, c + 3 + lat_of(d), er, 1'b0);
        repeat (lat_of(d) + 3) @(negedge clk);
        scramble(d);
        drain();
    endtask

    initial begin
        rst       = 3'b000;
        mem_read  = 3'b000;
        mem_write = 3'b000;
        for (int d = 0; d < 3; d++) begin
            addr[d]  = '0;
            wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_rdata", d, rdata[d], 32'd0);
            check("reset_ready", d, 32'(ready[d]), 32'd0);
            check("reset_busy", d, 32'(busy[d]), 32'd0);
            check("reset_misaligned", d, 32'(misaligned[d]), 32'd0);
            check("reset_state", d, 32'(dbg_state[d]), 32'd0);
        end
        rst      = 3'b111;
        chk_busy = 3'b111;

        // LATENCY=1
        req(0, 1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0);
        req(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0);
        held_read(0, 32'h0, 32'h0BAD_F00D);

        // LATENCY=4
        req(2, 1'b0, 1'b1, 32'h0, 32'h1357_9BDF, 32'h0, 1'b0);
        req(2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0);
        req(2, 1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);

        // LATENCY=2 main sequence
        req(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        req(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(1, 1'b1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        req(1, 1'b0, 1'b1, 32'h13, 32'h55, 32'h0, 1'b1);
        req(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(1, 1'b1, 1'b1, 32'h20, 32'h1234, 32'hDEAD_BEEF, 1'b0);
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234, 1'b0);
        req(1, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 32'h1234, 1'b0);
        req(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0);
        req(1, 1'b1, 1'b0, 32'hFFFF_FC00, 32'h0, 32'hA5A5_A5A5, 1'b0);
        req(1, 1'b0, 1'b1, 32'h8, 32'h1111_2222, 32'hA5A5_A5A5, 1'b0);

        // Reset held over the whole WAIT window including the commit edge.
        @(negedge clk);
        chk_busy[1]  = 1'b0;
        mem_write[1] = 1'b1;
        addr[1]      = 32'h8;
        wdata[1]     = 32'hFFFF_FFFF;
        @(negedge clk);
        scramble(1);
        rst[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        check("abort_rdata", 1, rdata[1], 32'd0);
        check("abort_ready", 1, 32'(ready[1]), 32'd0);
        check("abort_busy", 1, 32'(busy[1]), 32'd0);
        check("abort_misaligned", 1, 32'(misaligned[1]), 32'd0);
        check("abort_state", 1, 32'(dbg_state[1]), 32'd0);
        chk_busy[1] = 1'b1;
        req(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h1111_2222, 1'b0);

        held_read(1, 32'h20, 32'h1234);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
